// File: rtl/regfile_sb.sv
// Register file with write-through bypass, per-register pending bit and a post-reset clear sweep.
// Reads are combinational; writes/claims land at the next edge; load/claim are ignored until ready.
module regfile_sb #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [AW-1:0]    dest,
    input  logic [WIDTH-1:0] in,
    input  logic             claim,
    input  logic [AW-1:0]    claim_reg,
    input  logic [AW-1:0]    src_a,
    input  logic [AW-1:0]    src_b,
    output logic [WIDTH-1:0] sr1_out,
    output logic [WIDTH-1:0] sr2_out,
    output logic             busy_a,
    output logic             busy_b,
    output logic             ready
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t           state_q;
    logic             ready_q;
    logic [AW-1:0]    idx_q;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_dat;

    logic             byp_a;
    logic             byp_b;

    // Sweep sequencer; ready is registered alongside the state so no reset path reaches outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == AW'(DEPTH - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= CLEAR;
                    idx_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Single write port shared by the sweep and writeback keeps the array RAM-mappable.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = dest;
        wr_dat  = in;
        if (!reset) begin
            if (state_q == CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_dat  = '0;
            end else if (load) begin
                wr_en   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_addr] <= wr_dat;
        end
    end

    // Claim is applied after load so a same-register claim leaves the entry pending.
    always_comb begin
        pend_d = pend_q;
        if (!reset) begin
            if (state_q == CLEAR) begin
                pend_d[idx_q] = 1'b0;
            end else begin
                if (load) begin
                    pend_d[dest] = 1'b0;
                end
                if (claim) begin
                    pend_d[claim_reg] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    assign byp_a = load && (dest == src_a);
    assign byp_b = load && (dest == src_b);

    assign ready   = ready_q;
    assign sr1_out = !ready_q ? '0 : (byp_a ? in : data_q[src_a]);
    assign sr2_out = !ready_q ? '0 : (byp_b ? in : data_q[src_b]);
    assign busy_a  = !ready_q || (pend_q[src_a] && !byp_a);
    assign busy_b  = !ready_q || (pend_q[src_b] && !byp_b);

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int A  = 3;
    localparam int WW = 32;
    localparam int WD = 16;
    localparam int WA = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, load, claim;
    logic [A-1:0] dest, claim_reg, src_a, src_b;
    logic [W-1:0] din;
    logic [W-1:0] sr1_out, sr2_out;
    logic         busy_a, busy_b, ready;

    logic          w_reset, w_load, w_claim;
    logic [WA-1:0] w_dest, w_claim_reg, w_src_a, w_src_b;
    logic [WW-1:0] w_in;
    logic [WW-1:0] w_sr1, w_sr2;
    logic          w_busy_a, w_busy_b, w_ready;

    int n_vec = 0;
    int n_err = 0;

    regfile_sb #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk(clk), .reset(reset), .load(load), .dest(dest), .in(din),
        .claim(claim), .claim_reg(claim_reg), .src_a(src_a), .src_b(src_b),
        .sr1_out(sr1_out), .sr2_out(sr2_out), .busy_a(busy_a), .busy_b(busy_b),
        .ready(ready)
    );

    regfile_sb #(.WIDTH(WW), .DEPTH(WD)) u_wide (
        .clk(clk), .reset(w_reset), .load(w_load), .dest(w_dest), .in(w_in),
        .claim(w_claim), .claim_reg(w_claim_reg), .src_a(w_src_a), .src_b(w_src_b),
        .sr1_out(w_sr1), .sr2_out(w_sr2), .busy_a(w_busy_a), .busy_b(w_busy_b),
        .ready(w_ready)
    );

    // Reference model: register contents, pending flags, and how many sweep edges remain.
    logic [W-1:0] m_data [D];
    bit           m_pend [D];
    int           m_clear = D;

    function automatic logic [W-1:0] exp_sr(input logic [A-1:0] s);
        if (m_clear > 0) return '0;
        if (load && dest == s) return din;
        return m_data[s];
    endfunction

    function automatic logic exp_busy(input logic [A-1:0] s);
        if (m_clear > 0) return 1'b1;
        return m_pend[s] && !(load && dest == s);
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_clear = D;
        end else if (m_clear > 0) begin
            m_data[D - m_clear] = '0;
            m_pend[D - m_clear] = 1'b0;
            m_clear--;
        end else begin
            if (load) begin
                m_data[dest] = din;
                m_pend[dest] = 1'b0;
            end
            if (claim) m_pend[claim_reg] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_inputs();
        load      = ($urandom_range(0, 1) == 1);
        claim     = ($urandom_range(0, 2) == 0);
        dest      = A'($urandom_range(0, D - 1));
        claim_reg = A'($urandom_range(0, D - 1));
        src_a     = A'($urandom_range(0, D - 1));
        src_b     = ($urandom_range(0, 3) == 0) ? src_a : A'($urandom_range(0, D - 1));
        din       = W'($urandom);
    endtask

    task automatic idle_inputs();
        load = 1'b0; claim = 1'b0; reset = 1'b0;
        dest = '0; claim_reg = '0; src_a = '0; src_b = '0; din = '0;
    endtask

    task automatic test_reset();
        logic [2*W+2:0] got, exp;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < D; c++) begin
            rand_inputs();
            @(negedge clk);
            got = {ready, busy_a, busy_b, sr1_out, sr2_out};
            exp = {1'b0, 1'b1, 1'b1, {W{1'b0}}, {W{1'b0}}};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset_sweep cyc=%0d got=%h exp=%h", c, got, exp);
            end
            tick();
        end
        idle_inputs();
        for (int r = 0; r < D; r++) begin
            src_a = A'(r);
            src_b = A'(D - 1 - r);
            @(negedge clk);
            got = {ready, busy_a, busy_b, sr1_out, sr2_out};
            exp = {1'b1, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset_done reg=%0d got=%h exp=%h", r, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        load = 1'b1; dest = 3'd3; din = 16'hBEEF; src_a = 3'd3;
        @(negedge clk);
        n_vec++;
        if (sr1_out !== 16'hBEEF) begin
            n_err++;
            $display("FAIL bypass_same_cycle got=%h exp=beef", sr1_out);
        end
        tick();
        load = 1'b0; din = 16'h0;
        @(negedge clk);
        n_vec++;
        if (sr1_out !== 16'hBEEF) begin
            n_err++;
            $display("FAIL bypass_stored got=%h exp=beef", sr1_out);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        claim = 1'b1; claim_reg = 3'd5; src_b = 3'd5;
        @(negedge clk);
        n_vec++;
        if (busy_b !== 1'b0) begin
            n_err++;
            $display("FAIL claim_no_bypass got=%b exp=0", busy_b);
        end
        tick();
        claim = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy_b !== 1'b1) begin
            n_err++;
            $display("FAIL claim_busy got=%b exp=1", busy_b);
        end
        tick();
        load = 1'b1; dest = 3'd5; din = 16'h1234;
        @(negedge clk);
        n_vec++;
        if ({busy_b, sr2_out} !== {1'b0, 16'h1234}) begin
            n_err++;
            $display("FAIL load_clears_busy got=%b/%h exp=0/1234", busy_b, sr2_out);
        end
        tick();
        load = 1'b0; din = '0;
        @(negedge clk);
        n_vec++;
        if ({busy_b, sr2_out} !== {1'b0, 16'h1234}) begin
            n_err++;
            $display("FAIL pending_cleared got=%b/%h exp=0/1234", busy_b, sr2_out);
        end
        tick();
    endtask

    task automatic test_claim_load_same();
        idle_inputs();
        claim = 1'b1; claim_reg = 3'd2; load = 1'b1; dest = 3'd2; din = 16'h00AA;
        tick();
        idle_inputs();
        src_a = 3'd2;
        @(negedge clk);
        n_vec++;
        if ({busy_a, sr1_out} !== {1'b1, 16'h00AA}) begin
            n_err++;
            $display("FAIL claim_wins got=%b/%h exp=1/00aa", busy_a, sr1_out);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        logic [2*W+2:0] got, exp;
        idle_inputs();
        for (int r = 0; r < D; r++) begin
            load = 1'b1; dest = A'(r); din = W'(16'h1111 * (r + 1));
            claim = (r % 2 == 0); claim_reg = A'(r);
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rand_inputs();
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < D; c++) begin
            rand_inputs();
            @(negedge clk);
            got = {ready, busy_a, busy_b, sr1_out, sr2_out};
            exp = {m_clear == 0, exp_busy(src_a), exp_busy(src_b), exp_sr(src_a), exp_sr(src_b)};
            n_vec++;
            if (got !== exp || ready !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset_sweep cyc=%0d got=%h exp=%h", c, got, exp);
            end
            tick();
        end
        idle_inputs();
        for (int r = 0; r < D; r++) begin
            src_a = A'(r);
            src_b = A'(r);
            @(negedge clk);
            n_vec++;
            if ({ready, busy_a, busy_b, sr1_out, sr2_out} !== {3'b100, {2*W{1'b0}}}) begin
                n_err++;
                $display("FAIL mid_reset_cleared reg=%0d rdy=%b busy=%b%b sr=%h/%h exp=1/00/0000",
                         r, ready, busy_a, busy_b, sr1_out, sr2_out);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [2*W+2:0] got, exp;
        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            reset = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            if (c > 0) begin
                got = {ready, busy_a, busy_b, sr1_out, sr2_out};
                exp = {m_clear == 0, exp_busy(src_a), exp_busy(src_b), exp_sr(src_a), exp_sr(src_b)};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL random cyc=%0d got=%h exp=%h", c, got, exp);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_wide();
        idle_inputs();
        w_load = 1'b0; w_claim = 1'b0; w_dest = '0; w_claim_reg = '0;
        w_src_a = '0; w_src_b = '0; w_in = '0;
        w_reset = 1'b1;
        tick();
        w_reset = 1'b0;
        for (int c = 0; c < WD; c++) begin
            w_load = 1'b1; w_dest = WA'(c); w_in = 32'hFFFF_FFFF;
            @(negedge clk);
            n_vec++;
            if ({w_ready, w_busy_a, w_sr1} !== {2'b01, 32'h0}) begin
                n_err++;
                $display("FAIL wide_sweep cyc=%0d rdy=%b busy=%b sr1=%h exp=0/1/0", c, w_ready, w_busy_a, w_sr1);
            end
            tick();
        end
        w_load = 1'b1; w_dest = 4'd15; w_in = 32'hDEADBEEF; w_src_a = 4'd15; w_src_b = 4'd7;
        @(negedge clk);
        n_vec++;
        if ({w_ready, w_sr1, w_sr2} !== {1'b1, 32'hDEADBEEF, 32'h0}) begin
            n_err++;
            $display("FAIL wide_bypass rdy=%b sr=%h/%h exp=1/deadbeef/00000000", w_ready, w_sr1, w_sr2);
        end
        tick();
        w_load = 1'b0; w_in = '0; w_src_a = 4'd15; w_src_b = 4'd15;
        @(negedge clk);
        n_vec++;
        if ({w_sr1, w_sr2, w_busy_a, w_busy_b} !== {32'hDEADBEEF, 32'hDEADBEEF, 2'b00}) begin
            n_err++;
            $display("FAIL wide_dual_read sr=%h/%h busy=%b%b exp=deadbeef x2, 00", w_sr1, w_sr2, w_busy_a, w_busy_b);
        end
        tick();
        w_src_a = 4'd7;
        @(negedge clk);
        n_vec++;
        if (w_sr1 !== 32'h0) begin
            n_err++;
            $display("FAIL wide_no_alias got=%h exp=00000000", w_sr1);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        w_reset = 1'b1; w_load = 1'b0; w_claim = 1'b0; w_dest = '0; w_claim_reg = '0;
        w_src_a = '0; w_src_b = '0; w_in = '0;
        test_reset();
        test_bypass();
        test_scoreboard();
        test_claim_load_same();
        test_mid_reset();
        test_random();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
